// File: rtl/conv_pkg.sv
// conv_pkg: shared FP32 constants and the tagged result entry of the conv output path
package conv_pkg;
  localparam int FP_W = 32;
  localparam int FP_SIGN = 31;
  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam int ENTRY_COORD_W = 8;
  typedef struct packed {
    logic last;
    logic [ENTRY_COORD_W-1:0] row;
    logic [ENTRY_COORD_W-1:0] col;
    logic [FP_W-1:0] data;
  } conv_entry_t;
endpackage

// File: rtl/conv_output_buffer_if.sv
// conv_output_buffer_if: tagged-result stream from the output buffer to the memory writer
interface conv_output_buffer_if #(
  parameter int DATA_W = 32,
  parameter int COORD_W = 8
);
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [COORD_W-1:0] out_row;
  logic [COORD_W-1:0] out_col;
  logic out_last;
  modport master (output out_valid, out_data, out_row, out_col, out_last, input out_ready);
  modport slave (input out_valid, out_data, out_row, out_col, out_last, output out_ready);
endinterface

// File: rtl/conv_fifo_mem.sv
// conv_fifo_mem: entry storage with one write port and an asynchronous read port
module conv_fifo_mem
  import conv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [AW-1:0] raddr,
  input conv_entry_t wdata,
  output conv_entry_t rdata
);
  conv_entry_t mem [DEPTH];
  // entries are cleared on reset so the head reads as zero until the first push
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/conv_output_buffer.sv
// conv_output_buffer: ReLU, (row,col,last) tagging and FWFT buffering of accumulator results
module conv_output_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DATA_W = FP_W,
  parameter int COORD_W = ENTRY_COORD_W
) (
  input logic clk,
  input logic rst,
  input logic [DATA_W-1:0] in_data,
  input logic in_valid,
  input logic frame_start,
  input logic [COORD_W-1:0] out_width,
  input logic [COORD_W-1:0] out_height,
  input logic relu_en,
  output logic [$clog2(DEPTH):0] count,
  output logic overflow,
  conv_output_buffer_if.master wr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [COORD_W-1:0] row, col, row_tag, col_tag, row_nxt, col_nxt, w_last, h_last;
  logic full, pop, drop, push, last;
  conv_entry_t wr_entry, rd_entry;
  assign full = count == CW'(DEPTH);
  assign pop = wr.out_valid && wr.out_ready;
  assign drop = in_valid && full && !pop;
  assign push = in_valid && !drop;
  // tag the incoming result and step the raster position, whether the result is kept or dropped
  always_comb begin
    w_last = out_width == '0 ? '0 : out_width - 1'b1;
    h_last = out_height == '0 ? '0 : out_height - 1'b1;
    row_tag = frame_start ? '0 : row;
    col_tag = frame_start ? '0 : col;
    last = row_tag == h_last && col_tag == w_last;
    col_nxt = !in_valid ? col_tag : col_tag == w_last ? '0 : col_tag + 1'b1;
    row_nxt = !in_valid ? row_tag : last ? '0 : col_tag == w_last ? row_tag + 1'b1 : row_tag;
    wr_entry = '{last: last, row: row_tag, col: col_tag,
                 data: relu_en && in_data[FP_SIGN] ? FP_POS_ZERO : in_data};
  end
  // pointers, occupancy, raster position and the sticky loss flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      row <= '0;
      col <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
      row <= row_nxt;
      col <= col_nxt;
      overflow <= drop || (overflow && !frame_start);
    end
  conv_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(push),
    .waddr(wr_ptr),
    .raddr(rd_ptr),
    .wdata(wr_entry),
    .rdata(rd_entry)
  );
  assign wr.out_valid = count != '0;
  assign wr.out_data = rd_entry.data;
  assign wr.out_row = rd_entry.row;
  assign wr.out_col = rd_entry.col;
  assign wr.out_last = rd_entry.last;
endmodule

// File: tb/tb_conv_output_buffer.sv
// tb_conv_output_buffer: directed and random checks against a queue-based raster model
module tb_conv_output_buffer;
  localparam int DEPTH = 16;
  typedef struct {
    bit last;
    int row;
    int col;
    logic [31:0] data;
  } ent_t;
  logic clk = 0, rst = 0;
  logic [31:0] in_data = 0;
  logic in_valid = 0, frame_start = 0, relu_en = 0;
  logic [7:0] out_width = 1, out_height = 1;
  logic [4:0] count;
  logic overflow;
  int errors = 0, checks = 0;
  ent_t q[$];
  int pix = 0;
  bit ovf = 0;
  conv_output_buffer_if #(.DATA_W(32), .COORD_W(8)) wr();
  conv_output_buffer #(.DEPTH(DEPTH), .DATA_W(32), .COORD_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .frame_start(frame_start), .out_width(out_width), .out_height(out_height),
    .relu_en(relu_en), .count(count), .overflow(overflow), .wr(wr.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 64'(wr.out_valid), 64'(q.size() != 0));
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".overflow"}, 64'(overflow), 64'(ovf));
    if (q.size() != 0) begin
      chk({tag, ".data"}, 64'(wr.out_data), 64'(q[0].data));
      chk({tag, ".row"}, 64'(wr.out_row), 64'(q[0].row));
      chk({tag, ".col"}, 64'(wr.out_col), 64'(q[0].col));
      chk({tag, ".last"}, 64'(wr.out_last), 64'(q[0].last));
    end
  endtask
  task automatic cyc(input string tag, input logic iv, input logic [31:0] d, input logic fs, input logic rdy);
    int w, h;
    bit popm, fullm;
    in_valid = iv;
    in_data = d;
    frame_start = fs;
    wr.out_ready = rdy;
    w = out_width == 0 ? 1 : int'(out_width);
    h = out_height == 0 ? 1 : int'(out_height);
    popm = q.size() != 0 && rdy;
    fullm = q.size() == DEPTH;
    if (fs) begin
      pix = 0;
      ovf = 0;
    end
    if (popm) void'(q.pop_front());
    if (iv) begin
      if (!fullm || popm)
        q.push_back('{last: pix == w * h - 1, row: pix / w, col: pix % w,
                      data: (relu_en && d[31]) ? 32'h0 : d});
      else ovf = 1;
      pix = (pix + 1) % (w * h);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    frame_start = 0;
    chk_all(tag);
  endtask
  initial begin
    wr.out_ready = 0;
    #1;
    chk("rst.valid", 64'(wr.out_valid), 0);
    chk("rst.count", 64'(count), 0);
    chk("rst.overflow", 64'(overflow), 0);
    chk("rst.data", 64'(wr.out_data), 0);
    chk("rst.row", 64'(wr.out_row), 0);
    chk("rst.col", 64'(wr.out_col), 0);
    chk("rst.last", 64'(wr.out_last), 0);
    @(negedge clk);
    rst = 1;
    out_width = 2;
    out_height = 2;
    cyc("tag0", 1, 32'h3F800000, 0, 1);
    chk("tag0.head", {wr.out_row, wr.out_col, 7'd0, wr.out_last}, {8'd0, 8'd0, 8'd0});
    cyc("tag1", 1, 32'h40000000, 0, 1);
    cyc("tag2", 1, 32'h40400000, 0, 1);
    cyc("tag3", 1, 32'h40800000, 0, 1);
    chk("tag3.head", {wr.out_row, wr.out_col, 7'd0, wr.out_last}, {8'd1, 8'd1, 8'd1});
    cyc("tag.drain", 0, 0, 0, 1);
    relu_en = 1;
    cyc("relu0", 1, 32'hBF800000, 1, 0);
    cyc("relu1", 1, 32'h80000000, 0, 0);
    cyc("relu2", 1, 32'h3F800000, 0, 0);
    cyc("relu.pop0", 0, 0, 0, 1);
    chk("relu.negzero", 64'(wr.out_data), 0);
    cyc("relu.pop1", 0, 0, 0, 1);
    chk("relu.pos", 64'(wr.out_data), 64'h3F800000);
    cyc("relu.pop2", 0, 0, 0, 1);
    relu_en = 0;
    out_width = 8;
    out_height = 4;
    cyc("ovf.push0", 1, $urandom, 1, 0);
    for (int i = 1; i < 17; i++) cyc("ovf.push", 1, $urandom, 0, 0);
    chk("ovf.count16", 64'(count), 16);
    chk("ovf.flag", 64'(overflow), 1);
    for (int i = 0; i < 16; i++) cyc("ovf.drain", 0, 0, 0, 1);
    cyc("ovf.pix18", 1, 32'h12345678, 0, 0);
    chk("ovf.pix18.col", 64'(wr.out_col), 1);
    chk("ovf.pix18.row", 64'(wr.out_row), 2);
    cyc("full.clear", 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) cyc("full.fill", 1, $urandom, 0, 0);
    cyc("full.pushpop", 1, 32'hCAFEF00D, 0, 1);
    chk("full.pushpop.count", 64'(count), 16);
    chk("full.pushpop.ovf", 64'(overflow), 0);
    for (int i = 0; i < 16; i++) cyc("full.drain", 0, 0, 0, 1);
    out_width = 3;
    out_height = 3;
    cyc("fr.start", 1, $urandom, 1, 0);
    for (int i = 1; i < 23; i++) cyc("fr.push", 1, $urandom, 0, 0);
    chk("fr.ovf.set", 64'(overflow), 1);
    cyc("fr.restart", 1, 32'h0BADBEEF, 1, 1);
    chk("fr.restart.ovf", 64'(overflow), 0);
    for (int i = 0; i < 16; i++) cyc("fr.drain", 1, $urandom, 0, 1);
    for (int i = 0; i < 16; i++) cyc("fr.empty", 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      logic fs;
      fs = $urandom_range(0, 39) == 0;
      if (fs) begin
        out_width = 8'($urandom_range(0, 4));
        out_height = 8'($urandom_range(0, 4));
      end
      relu_en = 1'($urandom);
      cyc("rnd", 1'($urandom_range(0, 3) != 0), $urandom, fs, 1'($urandom_range(0, 2) == 0));
    end
    out_width = 4;
    out_height = 4;
    cyc("ar.start", 1, $urandom, 1, 0);
    for (int i = 1; i < 18; i++) cyc("ar.fill", 1, $urandom, 0, 0);
    #2;
    rst = 0;
    #1;
    chk("ar.valid", 64'(wr.out_valid), 0);
    chk("ar.count", 64'(count), 0);
    chk("ar.overflow", 64'(overflow), 0);
    q.delete();
    pix = 0;
    ovf = 0;
    @(negedge clk);
    rst = 1;
    cyc("ar.first", 1, 32'h3F800000, 0, 0);
    chk("ar.first.pos", {wr.out_row, wr.out_col}, 16'd0);
    cyc("ar.second", 1, 32'h40000000, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
